// File: rtl/cpu_run_ctrl_if.sv
// Run-control bus between cpu_run_ctrl and its environment.
// The instret counter output exists only when RUN_CTRL_INSTRET_EN is defined.
interface cpu_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             restart;
  logic             commit_vld;
  logic [PC_W-1:0]  commit_pc;
  logic             cpu_reset;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycles;
`ifdef RUN_CTRL_INSTRET_EN
  logic [CNT_W-1:0] instret;
`endif

  // Controller side: consumes commits and restart, produces run status.
  modport master (
    input  restart, commit_vld, commit_pc,
    output cpu_reset, running, done, timeout, cycles
`ifdef RUN_CTRL_INSTRET_EN
    , output instret
`endif
  );

  // Environment side: CPU/test harness that observes the status.
  modport slave (
    output restart, commit_vld, commit_pc,
    input  cpu_reset, running, done, timeout, cycles
`ifdef RUN_CTRL_INSTRET_EN
    , input instret
`endif
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: holds the CPU in reset for RST_CYCLES, lets it run,
// and stops it either when the same PC retires HALT_REPEAT times in a row
// (halt loop) or when MAX_CYCLES run cycles have elapsed.
// Optional feature macro: RUN_CTRL_INSTRET_EN adds a retired-instruction
// counter on the interface.
module cpu_run_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 4,
  parameter int MAX_CYCLES  = 100000,
  parameter int HALT_REPEAT = 3
) (
  input logic              clk,
  input logic              reset,
  cpu_run_ctrl_if.master   bus
);

  localparam int REP_W = $clog2(HALT_REPEAT + 1);

  localparam logic [7:0]       HOLD_LAST = 8'(RST_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       hold_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             last_vld;
  logic [PC_W-1:0]  last_pc;
  logic [CNT_W-1:0] cycles_q;
  logic             cpu_reset_q;
  logic             running_q;
  logic             done_q;
  logic             timeout_q;

  logic same_pc;
  logic halt_hit;

  // A commit repeats the previous PC only once a previous PC has been seen
  // in this run; the commit that completes HALT_REPEAT in a row halts.
  assign same_pc  = bus.commit_vld && last_vld && (bus.commit_pc == last_pc);
  assign halt_hit = same_pc && (rep_cnt == REP_LAST);

  // Run-control FSM with registered status outputs and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      last_vld    <= 1'b0;
      cycles_q    <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state       <= RUN;
            hold_cnt    <= '0;
            cpu_reset_q <= 1'b0;
            running_q   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RUN: begin
          cycles_q <= cycles_q + 1'b1;
          if (bus.commit_vld) begin
            last_vld <= 1'b1;
            if (same_pc) rep_cnt <= rep_cnt + 1'b1;
            else         rep_cnt <= REP_W'(1);
          end
          // Halt takes priority over a timeout landing on the same edge.
          if (halt_hit) begin
            state     <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (cycles_q == CYC_LAST) begin
            state     <= TOUT;
            running_q <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        DONE, TOUT: begin
          if (bus.restart) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            last_vld    <= 1'b0;
            cycles_q    <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  // Last committed PC; qualified by last_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == RUN && bus.commit_vld && !same_pc) last_pc <= bus.commit_pc;
  end

`ifdef RUN_CTRL_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  // Retired-instruction counter: counts RUN commits, cleared by restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (state == RUN && bus.commit_vld) begin
      instret_q <= instret_q + 1'b1;
    end else if ((state == DONE || state == TOUT) && bus.restart) begin
      instret_q <= '0;
    end
  end

  assign bus.instret = instret_q;
`endif

  assign bus.cpu_reset = cpu_reset_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.cycles    = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: directed scenarios followed by random
// stimulus, checked against a behavioural model of the run controller.
module tb_cpu_run_ctrl;
  localparam int PC_W = 32;
  localparam int CNT_W = 32;
  localparam int RST  = 4;
  localparam int MAXC = 20;
  localparam int HR   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RST),
    .MAX_CYCLES(MAXC), .HALT_REPEAT(HR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  typedef struct {
    logic             cpu_reset;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] instret;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Behavioural model: remaining hold cycles, run length, and the commit
  // history of the current run (a halt is HR identical trailing PCs).
  int              m_hold;
  int              m_cycles;
  int              m_instret;
  bit              m_done;
  bit              m_tout;
  logic [PC_W-1:0] m_pcs[$];

  function automatic void model_reset();
    m_hold = RST; m_cycles = 0; m_instret = 0;
    m_done = 0; m_tout = 0; m_pcs.delete();
  endfunction

  function automatic void model_step(bit rs, bit cv, logic [PC_W-1:0] pc);
    bit same;
    if (m_hold > 0) begin
      m_hold--;
    end else if (!m_done && !m_tout) begin
      m_cycles++;
      if (cv) begin
        m_instret++;
        m_pcs.push_back(pc);
        if (m_pcs.size() > HR) void'(m_pcs.pop_front());
        same = (m_pcs.size() == HR);
        foreach (m_pcs[i]) if (m_pcs[i] != m_pcs[0]) same = 0;
        if (same) m_done = 1;
      end
      if (!m_done && m_cycles == MAXC) m_tout = 1;
    end else if (rs) begin
      model_reset();
    end
  endfunction

  function automatic snap_t model_out();
    snap_t s;
    s.cpu_reset = (m_hold > 0);
    s.running   = (m_hold == 0) && !m_done && !m_tout;
    s.done      = m_done;
    s.timeout   = m_tout;
    s.cycles    = CNT_W'(m_cycles);
    s.instret   = CNT_W'(m_instret);
    return s;
  endfunction

  task automatic drive(bit rst_n, bit rs, bit cv, logic [PC_W-1:0] pc);
    @(negedge clk);
    reset = rst_n;
    bus.restart = rs;
    bus.commit_vld = cv;
    bus.commit_pc = pc;
    if (!rst_n) model_reset();
    else model_step(rs, cv, pc);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(int n);
    repeat (n) drive(1, 0, 0, '0);
  endtask

  task automatic commit(logic [PC_W-1:0] pc);
    drive(1, 0, 1, pc);
  endtask

  task automatic check_now(string name, logic [CNT_W-1:0] act, logic [CNT_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: after every rising edge compare DUT outputs to the next
  // expected snapshot.
  initial begin
    snap_t e;
    snap_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.cpu_reset = bus.cpu_reset;
        a.running   = bus.running;
        a.done      = bus.done;
        a.timeout   = bus.timeout;
        a.cycles    = bus.cycles;
`ifdef RUN_CTRL_INSTRET_EN
        a.instret   = bus.instret;
`else
        a.instret   = e.instret;
`endif
        checks++;
        if (a.cpu_reset !== e.cpu_reset || a.running !== e.running ||
            a.done !== e.done || a.timeout !== e.timeout ||
            a.cycles !== e.cycles || a.instret !== e.instret) begin
          failures++;
          $display("FAIL status t=%0t actual rst=%0b run=%0b done=%0b tout=%0b cyc=%0d ir=%0d required rst=%0b run=%0b done=%0b tout=%0b cyc=%0d ir=%0d",
                   $time, a.cpu_reset, a.running, a.done, a.timeout, a.cycles, a.instret,
                   e.cpu_reset, e.running, e.done, e.timeout, e.cycles, e.instret);
        end
      end
    end
  end

  initial begin
    int waitc;
    bus.restart = 0;
    bus.commit_vld = 0;
    bus.commit_pc = '0;
    model_reset();

    // Asynchronous reset before any clock edge.
    #2 reset = 0;
    #1;
    check_now("reset_cpu_reset", CNT_W'(bus.cpu_reset), 1);
    check_now("reset_running", CNT_W'(bus.running), 0);
    check_now("reset_done", CNT_W'(bus.done), 0);
    check_now("reset_cycles", bus.cycles, 0);

    // Reset low two cycles, then hold and run.
    drive(0, 0, 0, '0);
    drive(0, 0, 0, '0);
    idle(RST + 2);

    // Halt loop with idle cycles between commits.
    commit(32'h3000); idle(1);
    commit(32'h3004); idle(1);
    commit(32'h3008); idle(1);
    commit(32'h3008); idle(1);
    commit(32'h3008);
    idle(3);

    // Restart from DONE, then a restart pulse while running is ignored.
    drive(1, 1, 0, '0);
    idle(RST + 2);
    drive(1, 1, 0, '0);
    idle(1);

    // Broken repeat sequence: no halt, runs into timeout.
    commit(32'h3008); commit(32'h3008); commit(32'h300c);
    commit(32'h3008); commit(32'h3008);
    idle(MAXC);

    // Restart from TOUT; timeout with no commits at all.
    drive(1, 1, 0, '0);
    idle(RST + MAXC + 3);

    // Halt landing on the timeout edge: halt wins.
    drive(1, 1, 0, '0);
    idle(RST + MAXC - 3);
    commit(32'h3010); commit(32'h3010); commit(32'h3010);
    idle(3);

    // Reset asserted mid-run between clock edges.
    drive(1, 1, 0, '0);
    idle(RST + 5);
    @(posedge clk);
    #3 reset = 0;
    #1;
    check_now("midrun_cpu_reset", CNT_W'(bus.cpu_reset), 1);
    check_now("midrun_cycles", bus.cycles, 0);
    check_now("midrun_running", CNT_W'(bus.running), 0);
    drive(0, 0, 0, '0);
    idle(RST + 3);

    // Random phase.
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0),
            bit'($urandom_range(0, 1)), 32'h3000 + 32'(4 * $urandom_range(0, 2)));
    end
    idle(2);

    waitc = 0;
    while (exp_q.size() > 0 && waitc < 50) begin
      @(posedge clk);
      waitc++;
    end
    #2;
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain actual_pending=%0d required_pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
